hazard_detection_unit: RTL and testbench
========================================

# hazard_detection_unit

Decode-stage hazard controller for the 5-stage RV64 pipeline. It compares the IF/ID source registers against the in-flight load in ID/EX and, on a load-use hazard, inserts exactly one bubble. To insert the bubble it drives `stall` into the control unit, which zeroes the ID/EX control fields, and it freezes the PC and IF/ID. It also turns a taken branch resolved in MEM into flushes of the three younger stages, and keeps saturating performance counters for stalls and flushes.

## Interface
Parameters:
- `CNT_W`, 16: width of each performance counter.

Ports:
- `clk`, in, 1: sole clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high. Sampled on `clk`.
- `if_id_opcode`, in, 7: opcode of the instruction in ID.
- `if_id_rs1`, in, 5: rs1 field of the instruction in ID.
- `if_id_rs2`, in, 5: rs2 field of the instruction in ID.
- `id_ex_rd`, in, 5: destination register of the instruction in EX.
- `id_ex_memread`, in, 1: the instruction in EX is a load.
- `branch_taken`, in, 1: a beq in MEM resolved taken (Branch & Zero).
- `stall`, out, 1: to the control unit's `stall`; forces a bubble into ID/EX.
- `pc_write`, out, 1: PC register enable.
- `if_id_write`, out, 1: IF/ID register enable.
- `if_id_flush`, out, 1: clear IF/ID to NOP.
- `id_ex_flush`, out, 1: clear ID/EX controls.
- `ex_mem_flush`, out, 1: clear EX/MEM controls.
- `stall_count`, out, CNT_W: number of load-use bubbles inserted; saturating.
- `flush_count`, out, CNT_W: number of taken-branch flushes; saturating.

## Operation
- Source-use decode from `if_id_opcode`:
  - rs1 is used for 0110011, 0000011, 0010011, 0100011 and 1100011.
  - rs2 is used for 0110011, 0100011 and 1100011 only.
  - Every other opcode uses neither source.
- Hazard condition: `hz = id_ex_memread & (id_ex_rd != 0) & ((use_rs1 & rs1 == id_ex_rd) | (use_rs2 & rs2 == id_ex_rd))`.
- FSM states: RUN, LSTALL.
  - RUN, `branch_taken`=1: assert all three flushes, leave `stall` at 0, go to RUN. Branch has priority over any hazard.
  - RUN, `hz`=1 and no branch: assert `stall`=1, `pc_write`=0 and `if_id_write`=0, then go to LSTALL.
  - RUN, otherwise: idle outputs, stay in RUN.
  - LSTALL: `hz` is ignored, because the bubble now in EX has MemRead=0. Outputs are idle unless `branch_taken`, which flushes as in RUN. Always return to RUN.
- Idle output values: `stall`=0, `pc_write`=1, `if_id_write`=1, all flushes 0.
- Counters:
  - `stall_count` increments by 1 on each RUN→LSTALL transition.
  - `flush_count` increments by 1 on each cycle with `branch_taken`=1.
  - Both saturate at 2^CNT_W−1 and never wrap.

## Timing
- `stall`, `pc_write`, `if_id_write` and the three flushes are combinational from the inputs and the state register, valid in the same cycle as the hazard or branch. Zero-cycle latency; the control unit and the pipeline registers sample them at the next edge.
- The state register and counters update on the rising edge of `clk`.
- Load-use penalty is exactly 1 cycle. A stall is never asserted in two consecutive cycles.
- Taken-branch penalty is 3 cycles: IF/ID, ID/EX and EX/MEM are cleared at the same edge that the PC loads the target.
- Reset:
  - While `reset`=1, all outputs take their idle values regardless of the inputs.
  - At the edge where `reset`=1: state becomes RUN and both counters become 0.
  - Reset during LSTALL aborts the stall, leaving state RUN after the edge.
- Simultaneous `branch_taken` and `hz`:
  - Flushes assert, no stall.
  - State stays RUN; `stall_count` is unchanged and `flush_count` increments.
- `id_ex_rd`=0 with `id_ex_memread`=1 never stalls.

## Test plan
- **Load-use on rs1.** `id_ex_memread`=1, `id_ex_rd`=5, ID holds `add x6,x5,x7` (opcode 0110011, rs1=5) → `stall`=1, `pc_write`=0, `if_id_write`=0 for 1 cycle. Next cycle, same ID inputs with `id_ex_memread`=0 → idle. `stall_count`=1.
- **rs2 false hazard.** `id_ex_rd`=3 with `memread`=1. ID holds `addi x4,x1,3` whose rs2 field decodes to 3 (opcode 0010011) → no stall. Same rd with `sd x3,0(x1)` (opcode 0100011, rs2=3) → stall.
- **x0 guard.** `id_ex_memread`=1, `id_ex_rd`=0, ID rs1=0 → `stall`=0 and `stall_count` unchanged.
- **Branch beats hazard.** `branch_taken`=1 in the same cycle as a valid load-use → `if_id_flush`, `id_ex_flush` and `ex_mem_flush` = 1, `stall`=0. Counters become `flush_count`=1, `stall_count`=0.
- **Saturation.** With CNT_W=4, force 20 taken-branch cycles → `flush_count` holds 15.
- **Reset mid-stall.** Enter LSTALL, assert `reset` for 1 cycle with `hz` still true → outputs idle during reset. After the edge, state is RUN and both counters are 0. The next cycle with `hz` true stalls again.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// Decode-stage hazard controller: one-bubble load-use stall, taken-branch flush
// of IF/ID, ID/EX and EX/MEM, and saturating stall/flush event counters.
module hazard_detection_unit #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       if_id_opcode,
   input  logic [4:0]       if_id_rs1,
   input  logic [4:0]       if_id_rs2,
   input  logic [4:0]       id_ex_rd,
   input  logic             id_ex_memread,
   input  logic             branch_taken,
   output logic             stall,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic {
      RUN,
      LSTALL
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic use_rs1, use_rs2;
   logic hz;
   logic enter_stall;
   logic flush_evt;

   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      unique case (if_id_opcode)
         OP_RTYPE, OP_STORE, OP_BRANCH: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         OP_LOAD, OP_IMM: use_rs1 = 1'b1;
         default: ;
      endcase
   end

   assign hz = id_ex_memread && (id_ex_rd != 5'd0) &&
               ((use_rs1 && (if_id_rs1 == id_ex_rd)) ||
                (use_rs2 && (if_id_rs2 == id_ex_rd)));

   // Reset forces idle outputs combinationally, so the counters and state
   // see no events during a reset cycle either.
   always_comb begin
      state_d      = RUN;
      stall        = 1'b0;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      enter_stall  = 1'b0;
      flush_evt    = 1'b0;
      if (!reset) begin
         unique case (state_q)
            RUN: begin
               if (branch_taken) begin
                  flush_evt = 1'b1;
               end else if (hz) begin
                  stall       = 1'b1;
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  enter_stall = 1'b1;
                  state_d     = LSTALL;
               end
            end
            LSTALL: begin
               if (branch_taken) flush_evt = 1'b1;
            end
            default: ;
         endcase
         if_id_flush  = flush_evt;
         id_ex_flush  = flush_evt;
         ex_mem_flush = flush_evt;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (enter_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: directed vector table, hand sequences for
// saturation and reset-mid-stall, then random stimulus against a reference model.
module tb_hazard_detection_unit;

   localparam logic [6:0] R   = 7'b0110011;
   localparam logic [6:0] LD  = 7'b0000011;
   localparam logic [6:0] IM  = 7'b0010011;
   localparam logic [6:0] ST  = 7'b0100011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] LUI = 7'b0110111;

   // {stall, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush}
   localparam logic [5:0] IDLE = 6'b011000;
   localparam logic [5:0] STL  = 6'b100000;
   localparam logic [5:0] FLU  = 6'b011111;

   typedef struct {
      logic       rst;
      logic       br;
      logic       mr;
      logic [6:0] op;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [5:0] exp_o;
      logic       chk_cnt;
      int         sc;
      int         fc;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] if_id_opcode;
   logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
   logic       id_ex_memread, branch_taken;

   logic        d_stall, d_pcw, d_ifw, d_iff, d_idf, d_exf;
   logic [15:0] d_sc, d_fc;
   logic        e_stall, e_pcw, e_ifw, e_iff, e_idf, e_exf;
   logic [3:0]  e_sc, e_fc;

   int total = 0;
   int bad   = 0;

   bit m_stalled = 1'b0;
   bit m_known   = 1'b0;
   int m_sc = 0, m_fc = 0, m_sc4 = 0, m_fc4 = 0;

   always #5 clk = ~clk;

   hazard_detection_unit dut (
      .clk(clk), .reset(reset), .if_id_opcode(if_id_opcode),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .id_ex_rd(id_ex_rd),
      .id_ex_memread(id_ex_memread), .branch_taken(branch_taken),
      .stall(d_stall), .pc_write(d_pcw), .if_id_write(d_ifw),
      .if_id_flush(d_iff), .id_ex_flush(d_idf), .ex_mem_flush(d_exf),
      .stall_count(d_sc), .flush_count(d_fc)
   );

   hazard_detection_unit #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .if_id_opcode(if_id_opcode),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .id_ex_rd(id_ex_rd),
      .id_ex_memread(id_ex_memread), .branch_taken(branch_taken),
      .stall(e_stall), .pc_write(e_pcw), .if_id_write(e_ifw),
      .if_id_flush(e_iff), .id_ex_flush(e_idf), .ex_mem_flush(e_exf),
      .stall_count(e_sc), .flush_count(e_fc)
   );

   function automatic vec_t mk(input logic rst, input logic br, input logic mr,
                               input logic [6:0] op, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [5:0] exp_o, input logic chk_cnt,
                               input int sc, input int fc);
      vec_t v;
      v.rst = rst; v.br = br; v.mr = mr; v.op = op; v.rs1 = rs1; v.rs2 = rs2;
      v.rd = rd; v.exp_o = exp_o; v.chk_cnt = chk_cnt; v.sc = sc; v.fc = fc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: which sources an opcode reads, straight from the opcode lists.
   function automatic bit model_hz();
      bit u1, u2;
      u1 = if_id_opcode inside {R, LD, IM, ST, BR};
      u2 = if_id_opcode inside {R, ST, BR};
      return id_ex_memread === 1'b1 && id_ex_rd != 0 &&
             ((u1 && if_id_rs1 == id_ex_rd) || (u2 && if_id_rs2 == id_ex_rd));
   endfunction

   function automatic logic [5:0] model_out();
      if (reset)                        return IDLE;
      if (branch_taken)                 return FLU;
      if (model_hz() && !m_stalled)     return STL;
      return IDLE;
   endfunction

   task automatic apply(input vec_t v);
      reset = v.rst; branch_taken = v.br; id_ex_memread = v.mr;
      if_id_opcode = v.op; if_id_rs1 = v.rs1; if_id_rs2 = v.rs2; id_ex_rd = v.rd;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".out"},  {d_stall, d_pcw, d_ifw, d_iff, d_idf, d_exf}, model_out());
      chk({tag, ".out4"}, {e_stall, e_pcw, e_ifw, e_iff, e_idf, e_exf}, model_out());
      if (m_known) begin
         chk({tag, ".sc"},  d_sc, m_sc);
         chk({tag, ".fc"},  d_fc, m_fc);
         chk({tag, ".sc4"}, e_sc, m_sc4);
         chk({tag, ".fc4"}, e_fc, m_fc4);
      end
   endtask

   task automatic finish_cycle();
      bit h;
      h = model_hz();
      if (reset) begin
         m_stalled = 0; m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0; m_known = 1;
      end else if (branch_taken) begin
         m_stalled = 0;
         if (m_fc < 65535) m_fc++;
         if (m_fc4 < 15) m_fc4++;
      end else if (h && !m_stalled) begin
         m_stalled = 1;
         if (m_sc < 65535) m_sc++;
         if (m_sc4 < 15) m_sc4++;
      end else begin
         m_stalled = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_row(input vec_t v, input string tag);
      apply(v);
      @(negedge clk);
      chk({tag, ".o"}, {d_stall, d_pcw, d_ifw, d_iff, d_idf, d_exf}, v.exp_o);
      if (v.chk_cnt) begin
         chk({tag, ".sc"}, d_sc, v.sc);
         chk({tag, ".fc"}, d_fc, v.fc);
      end
      check_model(tag);
      finish_cycle();
   endtask

   vec_t tbl[$];
   vec_t rv;
   logic [6:0] ops [7];

   initial begin
      ops = '{R, LD, IM, ST, BR, JAL, LUI};
      tbl.push_back(mk(1, 0, 1, R,  5, 7, 5, IDLE, 0, 0, 0)); // reset with hazard present
      tbl.push_back(mk(0, 0, 0, R,  0, 0, 0, IDLE, 1, 0, 0)); // reset state
      tbl.push_back(mk(0, 0, 1, R,  5, 7, 5, STL,  1, 0, 0)); // load-use rs1
      tbl.push_back(mk(0, 0, 0, R,  5, 7, 5, IDLE, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, IM, 1, 3, 3, IDLE, 1, 1, 0)); // addi: rs2 field unused
      tbl.push_back(mk(0, 0, 1, ST, 1, 3, 3, STL,  1, 1, 0)); // sd: rs2 hazard
      tbl.push_back(mk(0, 0, 1, ST, 1, 3, 3, IDLE, 1, 2, 0)); // LSTALL ignores hz
      tbl.push_back(mk(0, 0, 1, R,  0, 0, 0, IDLE, 1, 2, 0)); // x0 guard
      tbl.push_back(mk(0, 0, 1, R,  0, 0, 0, IDLE, 1, 2, 0));
      tbl.push_back(mk(0, 1, 1, R,  5, 7, 5, FLU,  1, 2, 0)); // branch beats hazard
      tbl.push_back(mk(0, 0, 0, R,  5, 7, 5, IDLE, 1, 2, 1));
      tbl.push_back(mk(0, 0, 1, R,  5, 7, 5, STL,  1, 2, 1));
      tbl.push_back(mk(0, 1, 1, R,  5, 7, 5, FLU,  1, 3, 1)); // branch in LSTALL
      tbl.push_back(mk(0, 0, 0, R,  5, 7, 5, IDLE, 1, 3, 2));
      tbl.push_back(mk(0, 0, 1, BR, 1, 9, 9, STL,  1, 3, 2)); // beq rs2 hazard
      tbl.push_back(mk(0, 0, 0, BR, 1, 9, 9, IDLE, 1, 4, 2));
      tbl.push_back(mk(0, 0, 1, LD, 2, 9, 9, IDLE, 1, 4, 2)); // load: rs2 unused
      tbl.push_back(mk(0, 0, 1, JAL, 9, 9, 9, IDLE, 1, 4, 2)); // neither source used
      tbl.push_back(mk(0, 0, 1, LD, 9, 2, 9, STL,  1, 4, 2)); // load rs1 hazard
      tbl.push_back(mk(0, 0, 0, R,  0, 0, 0, IDLE, 1, 5, 2));

      apply(tbl[0]);
      @(posedge clk);
      #1;
      foreach (tbl[i]) run_row(tbl[i], $sformatf("tbl%0d", i));

      // Branch beats hazard from a fresh reset
      run_row(mk(1, 0, 0, R, 0, 0, 0, IDLE, 0, 0, 0), "bbh.rst");
      run_row(mk(0, 1, 1, R, 5, 7, 5, FLU,  1, 0, 0), "bbh.br");
      run_row(mk(0, 0, 0, R, 5, 7, 5, IDLE, 1, 0, 1), "bbh.after");

      // Reset mid-stall with hazard held
      run_row(mk(0, 0, 1, R, 5, 7, 5, STL,  1, 0, 1), "rms.stall");
      run_row(mk(1, 0, 1, R, 5, 7, 5, IDLE, 0, 0, 0), "rms.rst");
      run_row(mk(0, 0, 1, R, 5, 7, 5, STL,  1, 0, 0), "rms.again");
      run_row(mk(0, 0, 0, R, 5, 7, 5, IDLE, 1, 1, 0), "rms.idle");

      // Saturation of the 4-bit instance
      for (int i = 0; i < 20; i++) run_row(mk(0, 1, 1, R, 5, 7, 5, FLU, 0, 0, 0), "sat.br");
      for (int i = 0; i < 20; i++) begin
         run_row(mk(0, 0, 1, R, 5, 7, 5, STL,  0, 0, 0), "sat.hz");
         run_row(mk(0, 0, 0, R, 5, 7, 5, IDLE, 0, 0, 0), "sat.idle");
      end
      @(negedge clk);
      chk("sat.fc4", e_fc, 15);
      chk("sat.sc4", e_sc, 15);
      chk("sat.fc16", d_fc, 20);
      chk("sat.sc16", d_sc, 21);
      @(posedge clk);
      #1;

      for (int i = 0; i < 600; i++) begin
         rv.rst = ($urandom_range(0, 39) == 0);
         rv.br  = ($urandom_range(0, 5) == 0);
         rv.mr  = ($urandom_range(0, 3) != 0);
         rv.op  = ops[$urandom_range(0, 6)];
         rv.rs1 = 5'($urandom_range(0, 7));
         rv.rs2 = 5'($urandom_range(0, 7));
         rv.rd  = 5'($urandom_range(0, 7));
         apply(rv);
         @(negedge clk);
         check_model("rnd");
         finish_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
